// File: rtl/pwm_buffered_generator.sv
// pwm_buffered_generator
//   Per-transducer PWM output stage. Folded RISE/FALL edges from the
//   preconditioner are captured into a shadow buffer on DONE and each channel
//   promotes them to its active set only at its own period boundary
//   (TIME[i]==0). A period is therefore never built from a mix of old and new
//   edges. Each channel then compares its time counter against the effective
//   edges and registers the PWM level.
//
//   Ports
//     CLK            system clock, rising edge
//     RST_N          asynchronous active-low reset
//     TIME[i]        per-channel period counter, 0..cycle-1
//     RISE[i]        folded rise edge, valid while DONE=1
//     FALL[i]        folded fall edge, valid while DONE=1
//     DONE           one-cycle capture strobe
//     PWM_OUT[i]     registered PWM level, 1 clock after TIME[i]
//     UPDATE_PENDING high while any channel holds uncommitted shadow edges

// One channel: shadow/active edge pairs, pending flag, comparator.
module pwm_buffered_lane #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tcnt,
  input  logic [WIDTH-1:0] rise,
  input  logic [WIDTH-1:0] fall,
  input  logic             done,
  output logic             pwm,
  output logic             pend_nxt
);
  logic [WIDTH-1:0] sh_r, sh_f, ac_r, ac_f;
  logic [WIDTH-1:0] er, ef;
  logic             pend, at_zero, commit, hit;

  always_comb begin
    at_zero = (tcnt == '0);
    commit  = at_zero & (pend | done);
    // Effective edges: a commit this cycle is already visible to the
    // comparator. DONE at the boundary bypasses the shadow entirely.
    er = ac_r;
    ef = ac_f;
    if (at_zero && done) begin
      er = rise;
      ef = fall;
    end else if (commit) begin
      er = sh_r;
      ef = sh_f;
    end
    // er==ef is zero duty, never full on.
    if (er < ef)      hit = (er <= tcnt) && (tcnt < ef);
    else if (er > ef) hit = (tcnt < ef) || (er <= tcnt);
    else              hit = 1'b0;
    // The boundary always clears pending: either the shadow is committed or
    // a coincident DONE went straight to active.
    pend_nxt = at_zero ? 1'b0 : (pend | done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r <= '0;
      sh_f <= '0;
      ac_r <= '0;
      ac_f <= '0;
      pend <= 1'b0;
      pwm  <= 1'b0;
    end else begin
      if (done) begin
        sh_r <= rise;
        sh_f <= fall;
      end
      if (commit) begin
        ac_r <= er;
        ac_f <= ef;
      end
      pend <= pend_nxt;
      pwm  <= hit;
    end
  end
endmodule

module pwm_buffered_generator #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [DEPTH-1:0][WIDTH-1:0] TIME,
  input  logic [DEPTH-1:0][WIDTH-1:0] RISE,
  input  logic [DEPTH-1:0][WIDTH-1:0] FALL,
  input  logic                        DONE,
  output logic [DEPTH-1:0]            PWM_OUT,
  output logic                        UPDATE_PENDING
);
  logic [DEPTH-1:0] pend_nxt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    pwm_buffered_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (CLK),
      .rst_n    (RST_N),
      .tcnt     (TIME[g]),
      .rise     (RISE[g]),
      .fall     (FALL[g]),
      .done     (DONE),
      .pwm      (PWM_OUT[g]),
      .pend_nxt (pend_nxt[g])
    );
  end

  // Registered OR of next-state pending: rises 1 clock after DONE, falls
  // 1 clock after the last channel commits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) UPDATE_PENDING <= 1'b0;
    else        UPDATE_PENDING <= |pend_nxt;
  end
endmodule

// File: tb/tb_pwm_buffered_generator.sv
module tb_pwm_buffered_generator;
  localparam int W   = 13;
  localparam int D   = 2;
  localparam int CYC = 4000;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic [D-1:0][W-1:0] TIME = '0;
  logic [D-1:0][W-1:0] RISE = '0;
  logic [D-1:0][W-1:0] FALL = '0;
  logic                DONE = 1'b0;
  logic [D-1:0]        PWM_OUT;
  logic                UPDATE_PENDING;

  pwm_buffered_generator #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST_N(RST_N), .TIME(TIME), .RISE(RISE), .FALL(FALL),
    .DONE(DONE), .PWM_OUT(PWM_OUT), .UPDATE_PENDING(UPDATE_PENDING)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Scoreboard entry: expected outputs after the edge that consumes a stimulus.
  typedef struct { logic [D-1:0] pwm; logic upd; } exp_t;
  exp_t sb[$];

  // Reference state: which edge set each channel is running, plus the
  // newest captured set waiting for that channel's wrap.
  int m_ar[D], m_af[D], m_sr[D], m_sf[D];
  bit m_pend[D];
  int tb_t = 0;   // next base time to drive
  int off1 = 2000;

  function automatic bit in_pulse(int t, int r, int f);
    // Pulse is the half-open arc [r, f) on the circular period.
    return ((t - r + CYC) % CYC) < ((f - r + CYC) % CYC);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < D; c++) begin
      m_ar[c] = 0; m_af[c] = 0; m_sr[c] = 0; m_sf[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic step(input bit d, input int r, input int f);
    exp_t e;
    int   t;
    @(negedge CLK);
    TIME[0] = W'(tb_t);
    TIME[1] = W'((tb_t + off1) % CYC);
    for (int c = 0; c < D; c++) begin
      RISE[c] = W'(r);
      FALL[c] = W'(f);
    end
    DONE = d;
    e.upd = 1'b0;
    for (int c = 0; c < D; c++) begin
      t = (c == 0) ? tb_t : (tb_t + off1) % CYC;
      if (d) begin m_sr[c] = r; m_sf[c] = f; end
      if (t == 0 && (d || m_pend[c])) begin
        m_ar[c] = m_sr[c]; m_af[c] = m_sf[c]; m_pend[c] = 0;
      end else if (d) m_pend[c] = 1;
      e.pwm[c] = in_pulse(t, m_ar[c], m_af[c]);
      e.upd |= m_pend[c];
    end
    sb.push_back(e);
    tb_t = (tb_t + 1) % CYC;
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("pwm", PWM_OUT, e.pwm);
    chk("upd", UPDATE_PENDING, e.upd);
  endtask

  task automatic run_to(input int t);
    while (tb_t != t) step(0, 0, 0);
  endtask

  // Drive base time t and check channel ch output for that time.
  task automatic probe(input string tag, input int t, input int ch, input bit v);
    run_to(t);
    step(0, 0, 0);
    chk(tag, PWM_OUT[ch], v);
  endtask

  initial begin
    model_clear();
    #1;
    chk("rst_pwm", PWM_OUT, 0);
    chk("rst_upd", UPDATE_PENDING, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Basic pulse
    run_to(10);
    step(1, 1000, 3000);
    chk("basic_upd_rise", UPDATE_PENDING, 1);
    probe("basic_old", 2000, 0, 0);
    run_to(3999); step(0, 0, 0);
    chk("basic_upd_held", UPDATE_PENDING, 1);
    step(0, 0, 0);
    chk("basic_upd_fall", UPDATE_PENDING, 0);
    probe("basic_999", 999, 0, 0);
    probe("basic_1000", 1000, 0, 1);
    probe("basic_2999", 2999, 0, 1);
    probe("basic_3000", 3000, 0, 0);

    // Wrap-around pulse
    run_to(100); step(1, 3500, 500);
    probe("wrap_0", 0, 0, 1);
    probe("wrap_499", 499, 0, 1);
    probe("wrap_500", 500, 0, 0);
    probe("wrap_3499", 3499, 0, 0);
    probe("wrap_3500", 3500, 0, 1);
    probe("wrap_3999", 3999, 0, 1);

    // Zero duty, then full-range boundaries
    run_to(100); step(1, 2000, 2000);
    probe("zero_0", 0, 0, 0);
    probe("zero_1999", 1999, 0, 0);
    probe("zero_2000", 2000, 0, 0);
    probe("zero_3999", 3999, 0, 0);
    run_to(100); step(1, 0, 3999);
    probe("bnd_0", 0, 0, 1);
    probe("bnd_3998", 3998, 0, 1);
    probe("bnd_3999", 3999, 0, 0);

    // Glitch-free update: two captures in one period, channel 1 offset 2000
    run_to(100); step(1, 100, 200);
    run_to(1000); step(1, 300, 400);
    probe("gl_ch1_old", 1350, 1, 1);   // ch1 TIME 3350, old (0,3999)
    probe("gl_ch0_old", 1500, 0, 1);   // ch0 still old
    probe("gl_ch1_150", 2150, 1, 0);   // ch1 TIME 150, new set only
    probe("gl_ch1_350", 2350, 1, 1);
    probe("gl_ch0_old2", 3000, 0, 1);
    probe("gl_ch0_150", 150, 0, 0);
    probe("gl_ch0_350", 350, 0, 1);
    probe("gl_ch0_399", 399, 0, 1);
    probe("gl_ch0_400", 400, 0, 0);

    // DONE coincident with TIME[0]==0
    run_to(0); step(1, 0, 2000);
    chk("sim_pwm0", PWM_OUT[0], 1);
    chk("sim_upd", UPDATE_PENDING, 1);  // ch1 still waiting
    probe("sim_1999", 1999, 0, 1);
    step(0, 0, 0);                       // ch1 wraps here
    chk("sim_pend0_clear", UPDATE_PENDING, 0);

    // Async reset with outputs high and an update pending
    run_to(100); step(1, 0, 3999);
    step(0, 0, 0);
    chk("ar_pre_pwm", PWM_OUT[0], 1);
    chk("ar_pre_upd", UPDATE_PENDING, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("ar_pwm", PWM_OUT, 0);
    chk("ar_upd", UPDATE_PENDING, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_clear();
    probe("ar_post_0", 0, 0, 0);
    probe("ar_post_1000", 1000, 0, 0);
    probe("ar_post_3999", 3999, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pwm_buffered_generator.md
# pwm_buffered_generator

Per-transducer PWM output stage that sits directly downstream of the PWM preconditioner. It captures the folded RISE/FALL edge arrays when the preconditioner signals completion and holds them in a shadow buffer. Each channel commits the new edges only at its own period boundary, so no output period is ever built from mixed old/new edges. It compares every channel's time counter against its active edges and drives the registered PWM outputs to the transducer drivers.

## Interface
Parameters:
- WIDTH, 13, bit width of time counters and edge values
- DEPTH, 249, number of transducer channels

Ports:
- CLK  input  1  single system clock; all logic on rising edge
- RST_N  input  1  reset, asynchronous and active-low
- TIME[0:DEPTH-1]  input  WIDTH each  per-channel period counter, counts 0..cycle-1 and wraps to 0
- RISE[0:DEPTH-1]  input  WIDTH each  folded rise edge from preconditioner, in [0, cycle-1]
- FALL[0:DEPTH-1]  input  WIDTH each  folded fall edge from preconditioner, in [0, cycle-1]
- DONE  input  1  one-cycle pulse from preconditioner; RISE/FALL valid in that cycle
- PWM_OUT[DEPTH-1:0]  output  DEPTH  registered PWM level per channel
- UPDATE_PENDING  output  1  high while any channel holds uncommitted shadow edges

## Operation
- State per channel i:
  - shadow_rise[i], shadow_fall[i]
  - active_rise[i], active_fall[i]
  - pending[i]
- Capture, on DONE=1:
  - shadow_rise[i] <= RISE[i] and shadow_fall[i] <= FALL[i], for all i.
  - pending[i] <= 1.
- Commit: when pending[i]=1 and TIME[i]==0:
  - active_rise[i] <= shadow_rise[i] and active_fall[i] <= shadow_fall[i].
  - pending[i] <= 0.
- Simultaneous DONE=1 and TIME[i]==0:
  - Active loads RISE[i]/FALL[i] directly. Shadow also loads them.
  - pending[i] <= 0. The new edges take effect this period.
- DONE while pending[i]=1: shadow is overwritten with the newest values and pending stays 1. Only the newest set is ever committed.
- Effective edges (er, ef) used by the comparator in a cycle:
  - The values being committed in that cycle, if a commit occurs.
  - Otherwise active_rise[i]/active_fall[i].
- Comparator, unsigned WIDTH-bit compare, t = TIME[i]:
  - er < ef: out = (er <= t) && (t < ef).
  - er > ef (wrap-around pulse): out = (t < ef) || (er <= t).
  - er == ef: out = 0. This is zero duty, never full on.
- UPDATE_PENDING <= OR of the next-state pending[] (registered).
- No per-channel FSM beyond the pending flag. Channel states are otherwise: IDLE (pending=0) and ARMED (pending=1).
  - IDLE to ARMED on DONE when TIME[i]!=0.
  - ARMED to IDLE on TIME[i]==0.

## Timing
- PWM_OUT[i] is registered. The value computed from TIME[i] in cycle n appears in cycle n+1. Latency is 1 clock.
- Shadow is written at the DONE edge. Commit happens at the first clock with TIME[i]==0 at or after DONE, latency 0 to cycle-1 clocks per channel.
- Channels commit independently. Different TIME phases give different commit cycles.
- UPDATE_PENDING:
  - Rises 1 clock after DONE, unless every channel commits in that same cycle.
  - Falls 1 clock after the last channel commits.
- Reset, RST_N=0, asynchronous:
  - PWM_OUT = 0 and UPDATE_PENDING = 0.
  - All shadow and active edges = 0 and all pending = 0.
  - Outputs stay 0 until after the first commit following reset release.
- Reset asserted mid-period or with pending set: all state clears immediately and the pending update is discarded.
- No handshake back to the preconditioner. DONE may arrive at any rate, including every clock. The last value wins.

## Test plan
- Basic pulse:
  - Stimulus: TIME sweeps 0..3999; DONE with RISE=1000, FALL=3000 at TIME=10.
  - Required response:
    - PWM_OUT[0]=0 for the rest of that period.
    - From the next TIME=0: high for TIME 1000..2999, seen 1 clock later.
    - UPDATE_PENDING high from DONE+1 until 1 clock after TIME=0.
- Wrap-around pulse:
  - Stimulus: RISE=3500, FALL=500, cycle 4000.
  - Required response: high for TIME 0..499 and 3500..3999. Low for 500..3499.
- Zero duty and boundaries:
  - Stimulus: RISE=FALL=2000, then RISE=0, FALL=3999.
  - Required response: first case constant 0. Second case high for TIME 0..3998, low at TIME 3999.
- Glitch-free update:
  - Stimulus: two DONE pulses in one period, first (100,200), then (300,400). Channels run with TIME offsets 0 and 2000.
  - Required response:
    - Only (300,400) is ever output.
    - Each channel switches at its own TIME=0.
    - The old edges are complete in the prior period.
- Simultaneous DONE and TIME==0:
  - Stimulus: DONE with (0,2000) in the cycle TIME[0]=0.
  - Required response: PWM_OUT[0] goes high 1 clock later in that same period. pending[0] stays 0.
- Async reset mid-operation:
  - Stimulus: assert RST_N=0 while outputs are high and UPDATE_PENDING=1. Release it, then issue no DONE.
  - Required response: all outputs 0 immediately, without waiting for a CLK edge. They remain 0 indefinitely after release.
